pipelined_addsub: RTL and testbench

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshaking. It is the successor to the team's single-cycle ripple-carry adder. The WIDTH-bit operation is split into STAGES equal chunks, with one chunk resolved per pipeline stage and the carry registered between stages. It sits in datapaths that need full-throughput wide adds at a clock rate where a full ripple chain cannot close timing.

---
 rtl/pipelined_addsub.sv | 141 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: WIDTH-bit two's-complement adder/subtractor split into STAGES
// equal chunks, one chunk resolved per stage with the carry registered in between.
// Valid/ready handshake with a global stall (the whole pipe freezes when the output
// beat is not taken).
// Optional feature: define PIPELINED_ADDSUB_SAT_EN for signed saturation of sum in
// the final stage (cout/ovf keep reporting the raw result).
module pipelined_addsub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned CW = WIDTH / STAGES;

    // Per-stage state: valid, carry out of the chunk, partial result (lower chunks
    // resolved so far) and the operands whose upper chunks are still to be added.
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  res_q [STAGES];
    logic [WIDTH-1:0]  res_d [STAGES];
    logic [WIDTH-1:0]  opa_q [STAGES];
    logic [WIDTH-1:0]  opa_d [STAGES];
    logic [WIDTH-1:0]  opb_q [STAGES];
    logic [WIDTH-1:0]  opb_d [STAGES];
    logic              ovf_q, ovf_d;

    // Inputs seen by each stage: stage 0 takes the prepared operands, the others
    // take the registers of the stage before them.
    logic [WIDTH-1:0]  src_a [STAGES];
    logic [WIDTH-1:0]  src_b [STAGES];
    logic [WIDTH-1:0]  src_r [STAGES];
    logic [STAGES-1:0] src_c;
    logic [STAGES-1:0] src_v;

    logic advance;

    // Global stall: everything moves only when the output slot is free or being taken.
    always_comb begin
        advance   = !valid_q[STAGES-1] || out_ready;
        in_ready  = advance;
        out_valid = valid_q[STAGES-1];
        sum       = res_q[STAGES-1];
        cout      = carry_q[STAGES-1];
        ovf       = ovf_q;
    end

    // Stage input selection; subtraction is a + ~b + ~borrow.
    always_comb begin
        src_a[0] = a;
        src_b[0] = b ^ {WIDTH{sub}};
        src_r[0] = '0;
        src_c[0] = cin ^ sub;
        src_v[0] = in_valid;
        for (int s = 1; s < STAGES; s++) begin
            src_a[s] = opa_q[s-1];
            src_b[s] = opb_q[s-1];
            src_r[s] = res_q[s-1];
            src_c[s] = carry_q[s-1];
            src_v[s] = valid_q[s-1];
        end
    end

    // Next state: each stage adds its own chunk; the last stage also derives overflow.
    always_comb begin
        logic [CW:0]      part;
        logic [WIDTH-1:0] r;
        logic             c_msb;
        part    = '0;
        r       = '0;
        c_msb   = 1'b0;
        valid_d = valid_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        for (int s = 0; s < STAGES; s++) begin
            res_d[s] = res_q[s];
            opa_d[s] = opa_q[s];
            opb_d[s] = opb_q[s];
        end
        if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                part = {1'b0, src_a[s][s*CW +: CW]} + {1'b0, src_b[s][s*CW +: CW]}
                     + {{CW{1'b0}}, src_c[s]};
                r    = src_r[s];
                r[s*CW +: CW] = part[CW-1:0];
                if (s == STAGES - 1) begin
                    // Carry into the MSB recovered from the MSB sum bit.
                    c_msb = src_a[s][WIDTH-1] ^ src_b[s][WIDTH-1] ^ r[WIDTH-1];
                    ovf_d = c_msb ^ part[CW];
`ifdef PIPELINED_ADDSUB_SAT_EN
                    if (c_msb ^ part[CW]) begin
                        r = src_a[s][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                              : {1'b0, {(WIDTH-1){1'b1}}};
                    end
`endif
                end
                res_d[s]   = r;
                carry_d[s] = part[CW];
                valid_d[s] = src_v[s];
                opa_d[s]   = src_a[s];
                opb_d[s]   = src_b[s];
            end
        end
    end

    // Stage registers with synchronous reset; reset discards all in-flight beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            ovf_q   <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                res_q[s] <= '0;
                opa_q[s] <= '0;
                opb_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            for (int s = 0; s < STAGES; s++) begin
                res_q[s] <= res_d[s];
                opa_q[s] <= opa_d[s];
                opb_q[s] <= opb_d[s];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench for pipelined_addsub: a 16-bit/4-stage instance driven with
// directed and random beats against an arithmetic reference model, plus an
// 8-bit/1-stage instance for the degenerate case.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [15:0] a, b, sum;

    logic        in_valid2, in_ready2, cin2, sub2, out_valid2, out_ready2, cout2, ovf2;
    logic [7:0]  a2, b2, sum2;

    pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf)
    );

    pipelined_addsub #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
        .cin(cin2), .sub(sub2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2),
        .cout(cout2), .ovf(ovf2)
    );

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    res_t exp_q[$];
    int   del_cyc[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands.
    function automatic res_t model(input logic [15:0] aa, input logic [15:0] bb,
                                   input logic ci, input logic su);
        res_t        r;
        logic [15:0] be;
        int          raw, sres, ce;
        be   = su ? ~bb : bb;
        ce   = int'(ci ^ su);
        raw  = int'(aa) + int'(be) + ce;
        sres = int'($signed(aa)) + int'($signed(be)) + ce;
        r.s  = raw[15:0];
        r.c  = raw[16];
        r.o  = (sres > 32767) || (sres < -32768);
`ifdef PIPELINED_ADDSUB_SAT_EN
        if (r.o) r.s = aa[15] ? 16'h8000 : 16'h7FFF;
`endif
        return r;
    endfunction

    // One clock: score the handshakes seen just before the edge, then advance.
    task automatic step();
        logic acc, del;
        res_t got, e;
        #3;
        acc = in_valid && in_ready && !rst;
        del = out_valid && out_ready && !rst;
        got = {sum, cout, ovf};
        if (del) begin
            chk("beat_has_expected_entry", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat_result", 32'(got), 32'(e));
            end
            del_cyc.push_back(cyc);
        end
        if (acc) exp_q.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
        cyc++;
        if (rst) exp_q.delete();
    endtask

    // Single beat into an idle pipe: measure latency and check its fields directly.
    task automatic single(input string tag, input logic [15:0] aa, input logic [15:0] bb,
                          input logic ci, input logic su, input logic [15:0] es,
                          input logic ec, input logic eo);
        int n;
        a = aa; b = bb; cin = ci; sub = su; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        chk({tag, "_ovf"}, ovf, eo);
    endtask

    initial begin
        logic [17:0] held;
        int          c0, n;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; sub2 = 1'b0; out_ready2 = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_in_ready_s1", in_ready2, 1);

        // Single-stage instance: 0x7F + 0x01 + 1
        a2 = 8'h7F; b2 = 8'h01; cin2 = 1'b1; in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        chk("s1_valid", out_valid2, 1);
`ifdef PIPELINED_ADDSUB_SAT_EN
        chk("s1_sum", sum2, 8'h7F);
`else
        chk("s1_sum", sum2, 8'h81);
`endif
        chk("s1_cout", cout2, 0);
        chk("s1_ovf", ovf2, 1);

        // Boundaries
        single("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
`ifdef PIPELINED_ADDSUB_SAT_EN
        single("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
`else
        single("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif
        single("zerosub", 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        step();

        // Back-to-back beats: results on consecutive cycles, 4 edges after first accept
        del_cyc.delete();
        c0 = cyc;
        for (int i = 1; i <= 8; i++) begin
            a = 16'(i); b = 16'(i * 256); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        repeat (6) step();
        chk("b2b_count", del_cyc.size(), 8);
        if (del_cyc.size() >= 8) begin
            for (int k = 0; k < 8; k++) chk("b2b_cycle", del_cyc[k] - c0, 4 + k);
        end

        // Fill the pipe with the output stalled, then hold for 3 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            in_valid = 1'b1;
            step();
        end
        chk("stall_in_ready", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        held = {sum, cout, ovf};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_hold", {sum, cout, ovf}, held);
            chk("stall_in_ready_hold", in_ready, 0);
        end
        out_ready = 1'b1;
        in_valid = 1'b0;
        repeat (8) step();
        chk("stall_drained", exp_q.size(), 0);

        // Reset with three beats in flight: none may ever appear
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_sum", sum, 0);
        chk("flush_in_ready", in_ready, 1);
        del_cyc.delete();
        repeat (8) step();
        chk("flush_no_beats", del_cyc.size(), 0);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        chk("final_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
